// File: rtl/axi_master_read_engine.sv
// Pipelined AXI4 read master: registered AR slice, in-order burst tracking FIFO,
// 1-entry R output register with beat counting and sticky RLAST/RID error flags.
module axi_master_read_engine #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 64,
    parameter int          ID_WIDTH        = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [3:0]  CACHE_VAL       = 4'b0011,
    parameter logic [2:0]  PROT_VAL        = 3'b000
) (
    input  logic                                 AClk,
    input  logic                                 ARst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                cmd_addr,
    input  logic [ID_WIDTH-1:0]                  cmd_id,
    input  logic [7:0]                           cmd_len,
    input  logic [2:0]                           cmd_size,
    input  logic [1:0]                           cmd_burst,
    output logic [ID_WIDTH-1:0]                  ARID,
    output logic [ADDR_WIDTH-1:0]                ARADDR,
    output logic [7:0]                           ARLEN,
    output logic [2:0]                           ARSIZE,
    output logic [1:0]                           ARBURST,
    output logic                                 ARLOCK,
    output logic [3:0]                           ARCACHE,
    output logic [2:0]                           ARPROT,
    output logic                                 ARVALID,
    input  logic                                 ARREADY,
    input  logic [ID_WIDTH-1:0]                  RID,
    input  logic [DATA_WIDTH-1:0]                RDATA,
    input  logic [1:0]                           RRESP,
    input  logic                                 RLAST,
    input  logic                                 RVALID,
    output logic                                 RREADY,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [ID_WIDTH-1:0]                  rsp_id,
    output logic [1:0]                           rsp_resp,
    output logic                                 rsp_last,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_len,
    output logic                                 err_id,
    output logic                                 idle
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [ID_WIDTH-1:0] fifo_id_r  [MAX_OUTSTANDING];
    logic [7:0]          fifo_len_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    outstanding_r, outstanding_nxt_s;
    logic [7:0]          beat_cnt_r;
    logic                arvalid_r, arvalid_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic                idle_r, idle_nxt_s;
    logic                err_len_r, err_id_r;
    logic                cmd_ready_s, rready_s, cmd_fire_s, r_fire_s;
    logic                fifo_empty_s, beat_ok_s, exp_last_s, pop_s;
    logic [ID_WIDTH-1:0] head_id_s;
    logic [7:0]          head_len_s;

    // Handshake qualifiers; ready signals are held low while in reset
    always_comb begin
        fifo_empty_s = (outstanding_r == {CNT_W{1'b0}});
        cmd_ready_s  = ARst & (~arvalid_r | ARREADY) & (outstanding_r < CNT_MAX);
        rready_s     = ARst & (~rsp_valid_r | rsp_ready);
        cmd_fire_s   = cmd_valid & cmd_ready_s;
        r_fire_s     = RVALID & rready_s;
        head_id_s    = fifo_id_r[rd_ptr_r];
        head_len_s   = fifo_len_r[rd_ptr_r];
        exp_last_s   = (beat_cnt_r == head_len_s);
        beat_ok_s    = r_fire_s & ~fifo_empty_s;
        pop_s        = beat_ok_s & exp_last_s;
    end

    // Next-state for AR valid, in-flight count, response valid and idle
    always_comb begin
        arvalid_nxt_s     = arvalid_r;
        outstanding_nxt_s = outstanding_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        if (cmd_fire_s) begin
            arvalid_nxt_s = 1'b1;
        end else if (ARREADY) begin
            arvalid_nxt_s = 1'b0;
        end else begin
            arvalid_nxt_s = arvalid_r;
        end
        case ({cmd_fire_s, pop_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
        if (beat_ok_s) begin
            rsp_valid_nxt_s = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_nxt_s = 1'b0;
        end else begin
            rsp_valid_nxt_s = rsp_valid_r;
        end
        idle_nxt_s = (outstanding_nxt_s == {CNT_W{1'b0}}) & ~arvalid_nxt_s & ~rsp_valid_nxt_s;
    end

    // State registers: AR slice, tracking FIFO, beat counter, R output slot, errors
    always_ff @(posedge AClk) begin
        if (!ARst) begin
            arvalid_r     <= 1'b0;
            ARID          <= {ID_WIDTH{1'b0}};
            ARADDR        <= {ADDR_WIDTH{1'b0}};
            ARLEN         <= 8'd0;
            ARSIZE        <= 3'd0;
            ARBURST       <= 2'd0;
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            outstanding_r <= {CNT_W{1'b0}};
            beat_cnt_r    <= 8'd0;
            rsp_valid_r   <= 1'b0;
            rsp_data      <= {DATA_WIDTH{1'b0}};
            rsp_id        <= {ID_WIDTH{1'b0}};
            rsp_resp      <= 2'd0;
            rsp_last      <= 1'b0;
            err_len_r     <= 1'b0;
            err_id_r      <= 1'b0;
            idle_r        <= 1'b1;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_id_r[i]  <= {ID_WIDTH{1'b0}};
                fifo_len_r[i] <= 8'd0;
            end
        end else begin
            arvalid_r     <= arvalid_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            idle_r        <= idle_nxt_s;
            if (cmd_fire_s) begin
                ARID                 <= cmd_id;
                ARADDR               <= cmd_addr;
                ARLEN                <= cmd_len;
                ARSIZE               <= cmd_size;
                ARBURST              <= cmd_burst;
                fifo_id_r[wr_ptr_r]  <= cmd_id;
                fifo_len_r[wr_ptr_r] <= cmd_len;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                beat_cnt_r <= 8'd0;
            end else if (beat_ok_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
            // rsp_last follows the tracked length, never RLAST itself
            if (beat_ok_s) begin
                rsp_data <= RDATA;
                rsp_id   <= RID;
                rsp_resp <= RRESP;
                rsp_last <= exp_last_s;
            end
            if ((r_fire_s & fifo_empty_s) | (beat_ok_s & (RLAST != exp_last_s))) begin
                err_len_r <= 1'b1;
            end
            if (beat_ok_s & (RID != head_id_s)) begin
                err_id_r <= 1'b1;
            end
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign RREADY      = rready_s;
    assign ARVALID     = arvalid_r;
    assign ARLOCK      = 1'b0;
    assign ARCACHE     = CACHE_VAL;
    assign ARPROT      = PROT_VAL;
    assign rsp_valid   = rsp_valid_r;
    assign outstanding = outstanding_r;
    assign err_len     = err_len_r;
    assign err_id      = err_id_r;
    assign idle        = idle_r;

endmodule

// File: tb/tb_axi_master_read_engine.sv
// Directed bench for axi_master_read_engine: single, burst, outstanding limit,
// backpressure, protocol errors, mid-burst reset, 256-beat burst and stray beat.
module tb_axi_master_read_engine;

    logic        AClk = 1'b0;
    logic        ARst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic        rsp_last;
    logic [2:0]  outstanding;
    logic        err_len, err_id, idle;

    int tests = 0;
    int fails = 0;

    axi_master_read_engine dut (
        .AClk(AClk), .ARst(ARst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .outstanding(outstanding), .err_len(err_len), .err_id(err_id), .idle(idle)
    );

    always #5 AClk = ~AClk;

    task automatic step();
        @(posedge AClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_len   = len;
        cmd_addr  = addr;
        #1;
        chk("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int r;
        int b;
        int c;
        int last_cnt;
        ARst = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_id = 4'd0; cmd_len = 8'd0;
        cmd_size = 3'd3; cmd_burst = 2'b01; ARREADY = 1'b1;
        RID = 4'd0; RDATA = 64'd0; RRESP = 2'd0; RLAST = 1'b0; RVALID = 1'b0; rsp_ready = 1'b1;
        step(); step();
        chk("rst_arvalid", {63'd0, ARVALID}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd1);
        chk("rst_errs", {62'd0, err_len, err_id}, 64'd0);
        ARst = 1'b1;
        step();

        // single beat
        send_cmd(4'd3, 8'd0, 32'h0000_1000);
        chk("t1_arvalid", {63'd0, ARVALID}, 64'd1);
        chk("t1_araddr", {32'd0, ARADDR}, 64'h1000);
        chk("t1_arid", {60'd0, ARID}, 64'd3);
        chk("t1_arlen", {56'd0, ARLEN}, 64'd0);
        chk("t1_arcache", {57'd0, ARCACHE, ARPROT}, {57'd0, 4'b0011, 3'b000});
        chk("t1_outstanding", {61'd0, outstanding}, 64'd1);
        step();
        chk("t1_arvalid_drop", {63'd0, ARVALID}, 64'd0);
        RVALID = 1'b1; RID = 4'd3; RDATA = 64'hA1; RLAST = 1'b1;
        #1;
        chk("t1_rready", {63'd0, RREADY}, 64'd1);
        step();
        RVALID = 1'b0;
        chk("t1_rsp", {rsp_data[55:0], 3'd0, rsp_valid, rsp_id}, {56'hA1, 3'd0, 1'b1, 4'd3});
        chk("t1_rsp_last", {63'd0, rsp_last}, 64'd1);
        chk("t1_outstanding_zero", {61'd0, outstanding}, 64'd0);
        step();
        chk("t1_idle", {63'd0, idle}, 64'd1);

        // 8-beat burst, contiguous
        send_cmd(4'd1, 8'd7, 32'h0000_2000);
        step();
        for (int i = 0; i < 8; i++) begin
            RVALID = 1'b1; RID = 4'd1; RDATA = 64'd100 + 64'(i); RLAST = (i == 7);
            step();
            chk("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t2_rsp_data", rsp_data, 64'd100 + 64'(i));
            chk("t2_rsp_last", {63'd0, rsp_last}, {63'd0, (i == 7)});
        end
        RVALID = 1'b0;
        step();
        chk("t2_done", {59'd0, outstanding, err_len, err_id, rsp_valid}, 64'd0);

        // outstanding limit with R held off
        cmd_valid = 1'b1; cmd_len = 8'd0;
        for (int k = 0; k < 4; k++) begin
            cmd_id = 4'(k);
            #1;
            chk("t3_cmd_ready_open", {63'd0, cmd_ready}, 64'd1);
            step();
        end
        cmd_id = 4'd4;
        #1;
        chk("t3_cmd_ready_full", {63'd0, cmd_ready}, 64'd0);
        chk("t3_outstanding_full", {61'd0, outstanding}, 64'd4);
        step();
        chk("t3_still_full", {60'd0, cmd_ready, outstanding}, {60'd0, 1'b0, 3'd4});
        RVALID = 1'b1; RLAST = 1'b1; RID = 4'd0; RDATA = 64'd0;
        step();
        chk("t3_after_pop", {61'd0, outstanding}, 64'd3);
        RID = 4'd1; RDATA = 64'd1;
        #1;
        chk("t3_cmd_ready_reopen", {63'd0, cmd_ready}, 64'd1);
        step();
        chk("t3_push_pop_same", {61'd0, outstanding}, 64'd3);
        cmd_id = 4'd5; RID = 4'd2; RDATA = 64'd2;
        step();
        cmd_valid = 1'b0;
        chk("t3_push5", {61'd0, outstanding}, 64'd3);
        for (int k = 3; k < 6; k++) begin
            RID = 4'(k); RDATA = 64'(k);
            step();
            chk("t3_drain_id", {60'd0, rsp_id}, 64'(k));
        end
        RVALID = 1'b0;
        step();
        chk("t3_done", {59'd0, outstanding, err_len, err_id, rsp_valid}, 64'd0);

        // backpressure: rsp_ready 1010...
        send_cmd(4'd2, 8'd3, 32'h0000_3000);
        step();
        r = 0; b = 0; c = 0;
        while (r < 4 && c < 40) begin
            rsp_ready = (c % 2 == 0);
            RVALID = (b < 4); RID = 4'd2; RDATA = 64'd200 + 64'(b); RLAST = (b == 3);
            #1;
            chk("t4_rready", {63'd0, RREADY}, {63'd0, (!rsp_valid || rsp_ready)});
            if (RVALID && RREADY) b++;
            if (rsp_valid && rsp_ready) begin
                chk("t4_rsp_data", rsp_data, 64'd200 + 64'(r));
                chk("t4_rsp_last", {63'd0, rsp_last}, {63'd0, (r == 3)});
                r++;
            end
            step();
            c++;
        end
        chk("t4_beats_received", 64'(r), 64'd4);
        RVALID = 1'b0; rsp_ready = 1'b1;
        step();
        chk("t4_done", {59'd0, outstanding, err_len, err_id, rsp_valid}, 64'd0);

        // early RLAST then wrong RID
        send_cmd(4'd2, 8'd3, 32'h0000_4000);
        for (int i = 0; i < 4; i++) begin
            RVALID = 1'b1; RID = 4'd2; RDATA = 64'(i); RLAST = (i == 1);
            step();
            chk("t5_err_len", {63'd0, err_len}, {63'd0, (i >= 1)});
        end
        chk("t5_last_at_len", {63'd0, rsp_last}, 64'd1);
        chk("t5_err_id_clear", {63'd0, err_id}, 64'd0);
        RVALID = 1'b0;
        send_cmd(4'd2, 8'd0, 32'h0000_5000);
        RVALID = 1'b1; RID = 4'd5; RLAST = 1'b1; RDATA = 64'h55;
        step();
        RVALID = 1'b0;
        chk("t5_err_id", {63'd0, err_id}, 64'd1);
        chk("t5_rsp_id_fwd", {60'd0, rsp_id}, 64'd5);
        chk("t5_outstanding", {61'd0, outstanding}, 64'd0);

        // reset mid-burst with AR still pending
        ARREADY = 1'b0;
        send_cmd(4'd7, 8'd15, 32'h0000_6000);
        for (int i = 0; i < 3; i++) begin
            RVALID = 1'b1; RID = 4'd7; RLAST = 1'b0; RDATA = 64'(i);
            step();
        end
        chk("t6_ar_held", {55'd0, ARVALID, ARLEN}, {55'd0, 1'b1, 8'd15});
        ARst = 1'b0; RVALID = 1'b0;
        step();
        chk("t6_arvalid", {63'd0, ARVALID}, 64'd0);
        chk("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t6_outstanding", {61'd0, outstanding}, 64'd0);
        chk("t6_errs", {62'd0, err_len, err_id}, 64'd0);
        chk("t6_idle", {63'd0, idle}, 64'd1);
        ARst = 1'b1; ARREADY = 1'b1;
        step();

        // 256-beat burst
        send_cmd(4'd1, 8'd255, 32'h0000_7000);
        last_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            RVALID = 1'b1; RID = 4'd1; RDATA = 64'(i); RLAST = (i == 255);
            step();
            if (rsp_last) last_cnt++;
        end
        RVALID = 1'b0;
        chk("t7_last_count", 64'(last_cnt), 64'd1);
        chk("t7_final", {rsp_data[61:0], rsp_last, err_len}, {62'd255, 1'b1, 1'b0});
        chk("t7_outstanding", {61'd0, outstanding}, 64'd0);

        // stray beat with nothing in flight
        step();
        RVALID = 1'b1; RID = 4'd0; RLAST = 1'b1;
        #1;
        chk("t8_rready", {63'd0, RREADY}, 64'd1);
        step();
        RVALID = 1'b0;
        chk("t8_err_len", {63'd0, err_len}, 64'd1);
        chk("t8_dropped", {63'd0, rsp_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
